// File: rtl/axis_2_fifo_packer.sv
// Packs PACK_RATIO AXI-Stream beats into one wide FIFO word, optionally tagged
// with {last, first-beat user, lane count - 1}. A tlast beat flushes a partial word.
module axis_2_fifo_packer #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int PACK_RATIO      = 2,
    parameter int STORE_META      = 1,
    localparam int CNT_W           = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1,
    localparam int META_W          = (STORE_META != 0) ? (2 + CNT_W) : 0,
    localparam int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH * PACK_RATIO + META_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_axis_tuser,
    input  logic                       i_axis_tvalid,
    output logic                       o_axis_tready,
    input  logic                       i_axis_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
    output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
    output logic                       o_fifo_w_stb,
    input  logic                       i_fifo_not_full,
    output logic [31:0]                o_word_count,
    output logic [15:0]                o_pkt_count,
    output logic                       o_busy
);

    localparam int                DATA_W    = AXIS_DATA_WIDTH * PACK_RATIO;
    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(PACK_RATIO - 1);

    logic [CNT_W-1:0]           lane_idx;
    logic [DATA_W-1:0]          acc;
    logic [DATA_W-1:0]          word_data;
    logic                       user_q;
    logic                       user_sel;
    logic                       out_valid;
    logic                       out_last;
    logic [FIFO_DATA_WIDTH-1:0] out_word;
    logic [FIFO_DATA_WIDTH-1:0] next_word;
    logic [31:0]                word_count;
    logic [15:0]                pkt_count;
    logic                       accept;
    logic                       complete;
    logic                       strobe;

    // Handshake: a beat transfers on any edge where tvalid & tready; tready depends
    // only on reset, the output register and not_full, never on tvalid/tlast.
    // The FIFO write happens in every cycle o_fifo_w_stb is high.
    assign o_axis_tready = i_rst_n & (~out_valid | i_fifo_not_full);
    assign strobe        = i_rst_n & out_valid & i_fifo_not_full;
    assign accept        = i_axis_tvalid & o_axis_tready;
    assign complete      = accept & ((lane_idx == LAST_LANE) | i_axis_tlast);
    assign user_sel      = (lane_idx == '0) ? i_axis_tuser : user_q;

    // Lanes above lane_idx are still zero because the accumulator clears on completion.
    always_comb begin
        word_data = acc;
        word_data[lane_idx * AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = i_axis_tdata;
    end

    generate
        if (STORE_META != 0) begin : g_meta
            assign next_word = {i_axis_tlast, user_sel, lane_idx, word_data};
        end else begin : g_no_meta
            assign next_word = word_data;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lane_idx   <= '0;
            acc        <= '0;
            user_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_word   <= '0;
            word_count <= '0;
            pkt_count  <= '0;
        end else begin
            if (accept) begin
                if (lane_idx == '0) begin
                    user_q <= i_axis_tuser;
                end
                if (complete) begin
                    lane_idx <= '0;
                    acc      <= '0;
                end else begin
                    lane_idx <= lane_idx + CNT_W'(1);
                    acc      <= word_data;
                end
            end

            // A completion on a strobe edge reloads the register with no bubble.
            if (complete) begin
                out_word  <= next_word;
                out_last  <= i_axis_tlast;
                out_valid <= 1'b1;
            end else if (strobe) begin
                out_valid <= 1'b0;
            end

            if (strobe) begin
                word_count <= word_count + 32'd1;
                if (out_last) begin
                    pkt_count <= pkt_count + 16'd1;
                end
            end
        end
    end

    assign o_fifo_data  = out_word;
    assign o_fifo_w_stb = strobe;
    assign o_word_count = word_count;
    assign o_pkt_count  = pkt_count;
    assign o_busy       = (lane_idx != '0) | out_valid;

endmodule
